// File: rtl/instruction_decoder.sv
// Instruction register and decoder: turns the fetched byte into register load
// enables, bus source select, ALU controls, jump controls and the zero flag.
module instruction_decoder #(
  parameter logic [7:0] NOP_CODE = 8'h80
) (
  input  logic       clk,
  input  logic       sync_reset,
  input  logic [7:0] pm_data,
  input  logic       alu_zero,
  output logic [7:0] ir,
  output logic [7:0] reg_en,
  output logic       r_en,
  output logic [3:0] source_sel,
  output logic [3:0] imm,
  output logic       x_sel,
  output logic       y_sel,
  output logic [2:0] alu_func,
  output logic       i_incr,
  output logic       jmp,
  output logic       jmp_nz,
  output logic [3:0] jmp_addr,
  output logic       dont_jmp
);

  localparam logic [3:0] SRC_IMM  = 4'd8;
  localparam logic [3:0] SRC_PINS = 4'd9;
  localparam logic [2:0] DST_DM   = 3'd7;
  localparam logic [2:0] DST_OREG = 3'd4;

  logic       zero_flag;
  logic [2:0] mv_dst;
  logic [2:0] mv_src;
  logic       dm_access;

  // Fetch stage: ir and the zero flag, which only ALU instructions update
  always_ff @(posedge clk) begin
    if (sync_reset) begin
      ir        <= NOP_CODE;
      zero_flag <= 1'b0;
    end else begin
      ir <= pm_data;
      if (ir[7:5] == 3'b110)
        zero_flag <= alu_zero;
    end
  end

  assign mv_dst   = ir[5:3];
  assign mv_src   = ir[2:0];
  assign imm      = ir[3:0];
  assign jmp_addr = ir[3:0];
  assign x_sel    = ir[4];
  assign y_sel    = ir[3];
  assign alu_func = ir[2:0];
  assign dont_jmp = zero_flag;

  // Decode stage: purely combinational from ir, gated off while in reset
  always_comb begin
    reg_en     = '0;
    r_en       = 1'b0;
    source_sel = 4'd0;
    i_incr     = 1'b0;
    jmp        = 1'b0;
    jmp_nz     = 1'b0;
    dm_access  = 1'b0;
    if (!sync_reset) begin
      if (!ir[7]) begin
        reg_en[ir[6:4]] = 1'b1;
        source_sel      = SRC_IMM;
        dm_access       = (ir[6:4] == DST_DM);
      end else if (!ir[6]) begin
        if (mv_dst != mv_src) begin
          reg_en[mv_dst] = 1'b1;
          source_sel     = {1'b0, mv_src};
          dm_access      = (mv_src == DST_DM) || (mv_dst == DST_DM);
        end else if (mv_dst == DST_OREG) begin
          // o_reg <- o_reg is repurposed as o_reg <- i_pins
          reg_en[DST_OREG] = 1'b1;
          source_sel       = SRC_PINS;
        end
      end else if (!ir[5]) begin
        r_en = 1'b1;
      end else if (ir[4]) begin
        jmp_nz = 1'b1;
      end else begin
        jmp = 1'b1;
      end
      // An explicit load of i takes priority over the dm post-increment
      i_incr = dm_access && !reg_en[6];
    end
  end

endmodule

// File: tb/tb_instruction_decoder.sv
// Directed bench for instruction_decoder: expected outputs are queued as each
// cycle's stimulus is driven and compared at the following falling edge.
module tb_instruction_decoder;

  logic       clk = 1'b0;
  logic       sync_reset;
  logic [7:0] pm_data;
  logic       alu_zero;
  logic [7:0] ir;
  logic [7:0] reg_en;
  logic       r_en;
  logic [3:0] source_sel;
  logic [3:0] imm;
  logic       x_sel;
  logic       y_sel;
  logic [2:0] alu_func;
  logic       i_incr;
  logic       jmp;
  logic       jmp_nz;
  logic [3:0] jmp_addr;
  logic       dont_jmp;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] ir;
    logic [7:0] reg_en;
    logic       r_en;
    logic [3:0] src;
    logic       chk_src;
    logic       i_incr;
    logic       jmp;
    logic       jmp_nz;
    logic       dont_jmp;
  } exp_t;

  exp_t sb[$];

  instruction_decoder #(.NOP_CODE(8'h80)) dut (
    .clk(clk), .sync_reset(sync_reset), .pm_data(pm_data), .alu_zero(alu_zero),
    .ir(ir), .reg_en(reg_en), .r_en(r_en), .source_sel(source_sel), .imm(imm),
    .x_sel(x_sel), .y_sel(y_sel), .alu_func(alu_func), .i_incr(i_incr),
    .jmp(jmp), .jmp_nz(jmp_nz), .jmp_addr(jmp_addr), .dont_jmp(dont_jmp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Inputs for the current cycle are applied just after the rising edge; the
  // expectation describes what the DUT shows during that same cycle.
  task automatic step(input logic [7:0] pm, input logic rst, input logic az,
                      input logic [7:0] e_ir, input logic [7:0] e_en, input logic e_r,
                      input logic [3:0] e_src, input logic e_chk_src, input logic e_inc,
                      input logic e_j, input logic e_jnz, input logic e_dj);
    exp_t e;
    @(posedge clk);
    #1;
    pm_data    = pm;
    sync_reset = rst;
    alu_zero   = az;
    e.ir = e_ir; e.reg_en = e_en; e.r_en = e_r; e.src = e_src; e.chk_src = e_chk_src;
    e.i_incr = e_inc; e.jmp = e_j; e.jmp_nz = e_jnz; e.dont_jmp = e_dj;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("ir", ir, e.ir);
      chk("reg_en", reg_en, e.reg_en);
      chk("r_en", {7'd0, r_en}, {7'd0, e.r_en});
      if (e.chk_src) chk("source_sel", {4'd0, source_sel}, {4'd0, e.src});
      chk("i_incr", {7'd0, i_incr}, {7'd0, e.i_incr});
      chk("jmp", {7'd0, jmp}, {7'd0, e.jmp});
      chk("jmp_nz", {7'd0, jmp_nz}, {7'd0, e.jmp_nz});
      chk("dont_jmp", {7'd0, dont_jmp}, {7'd0, e.dont_jmp});
      chk("imm", {4'd0, imm}, {4'd0, e.ir[3:0]});
      chk("jmp_addr", {4'd0, jmp_addr}, {4'd0, e.ir[3:0]});
      chk("x_sel", {7'd0, x_sel}, {7'd0, e.ir[4]});
      chk("y_sel", {7'd0, y_sel}, {7'd0, e.ir[3]});
      chk("alu_func", {5'd0, alu_func}, {5'd0, e.ir[2:0]});
    end
  end

  initial begin
    sync_reset = 1'b1;
    pm_data    = 8'hFF;
    alu_zero   = 1'b0;
    repeat (2) @(posedge clk);

    //    pm     rst   az    ir     reg_en        r_en  src  chk  inc   jmp   jnz   dj
    step(8'hFF, 1'b1, 1'b0, 8'h80, 8'b0000_0000, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(8'hFF, 1'b0, 1'b0, 8'h80, 8'b0000_0000, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(8'h35, 1'b0, 1'b0, 8'hFF, 8'b0000_0000, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(8'h8F, 1'b0, 1'b0, 8'h35, 8'b0000_1000, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(8'hB7, 1'b0, 1'b0, 8'h8F, 8'b0000_0010, 1'b0, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(8'h92, 1'b0, 1'b0, 8'hB7, 8'b0100_0000, 1'b0, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(8'hA4, 1'b0, 1'b0, 8'h92, 8'b0000_0000, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(8'hD8, 1'b0, 1'b0, 8'hA4, 8'b0001_0000, 1'b0, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // ALU with result zero: the flag picks up alu_zero at the next edge
    step(8'hF3, 1'b0, 1'b1, 8'hD8, 8'b0000_0000, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(8'hE7, 1'b0, 1'b0, 8'hF3, 8'b0000_0000, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step(8'hD8, 1'b0, 1'b0, 8'hE7, 8'b0000_0000, 1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(8'hD8, 1'b0, 1'b0, 8'hD8, 8'b0000_0000, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(8'h8F, 1'b0, 1'b1, 8'hD8, 8'b0000_0000, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    // Reset while x1 <- dm sits in ir: nothing may be enabled
    step(8'h00, 1'b1, 1'b0, 8'h8F, 8'b0000_0000, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(8'h00, 1'b0, 1'b0, 8'h80, 8'b0000_0000, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0, 8'h00, 8'b0000_0001, 1'b0, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $error("FAIL drain: observed %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_decoder.md
Name: instruction_decoder

Overview:
- Sits directly downstream of program_sequencer and the synchronous program memory.
- Registers the fetched instruction byte (pm_data) into the instruction register ir.
- Decodes ir into register load enables, data-bus source select, ALU controls and the jump controls (jmp, jmp_nz, jmp_addr) that feed program_sequencer.
- Owns the zero-flag register that drives dont_jmp.

Parameters:
- NOP_CODE, 8'h80, value forced into ir on reset (move x0->x0).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- sync_reset  input  1  synchronous, active-high reset.
- pm_data  input  8  instruction byte from program memory.
- alu_zero  input  1  combinational "ALU result == 0" from the computational unit.
- ir  output  8  instruction register.
- reg_en  output  8  one-hot destination load enable: 0 x0, 1 x1, 2 y0, 3 y1, 4 o_reg, 5 m, 6 i, 7 dm write.
- r_en  output  1  ALU result register load enable.
- source_sel  output  4  data-bus source: 0 x0, 1 x1, 2 y0, 3 y1, 4 r, 5 m, 6 i, 7 dm, 8 immediate, 9 i_pins.
- imm  output  4  immediate field, ir[3:0].
- x_sel  output  1  ALU x operand select, ir[4].
- y_sel  output  1  ALU y operand select, ir[3].
- alu_func  output  3  ALU function, ir[2:0].
- i_incr  output  1  post-increment request, i <= i + m.
- jmp  output  1  unconditional jump to program_sequencer.
- jmp_nz  output  1  conditional jump (jump if not zero).
- jmp_addr  output  4  jump target nibble, ir[3:0].
- dont_jmp  output  1  equals the zero_flag register.

Behaviour:
- ir register:
  - Rising edge: sync_reset -> ir <= NOP_CODE; otherwise ir <= pm_data.
  - Latency: one cycle from pm_data to ir. All decode outputs are combinational from ir.
- Reset:
  - While sync_reset = 1, reg_en, r_en, i_incr, jmp and jmp_nz are forced to 0 combinationally.
  - zero_flag <= 0, so dont_jmp = 0 after reset.
  - Reset mid-instruction discards the instruction; no partial enable is ever issued.
  - The first cycle after reset decodes NOP_CODE, so no enables are active.
- Default values: all enables 0; source_sel = 0.
- imm, jmp_addr, x_sel, y_sel and alu_func are pure bit-slices of ir at all times, with no gating.
- Load (ir[7] = 0):
  - dst = ir[6:4]; reg_en[dst] = 1; source_sel = 8.
- Move (ir[7:6] = 2'b10):
  - dst = ir[5:3], src = ir[2:0].
  - dst != src: reg_en[dst] = 1; source_sel = src.
  - dst == src == 4: reg_en[4] = 1 (o_reg); source_sel = 9 (i_pins).
  - dst == src, any other value: no-op, all enables 0.
- ALU (ir[7:5] = 3'b110):
  - r_en = 1.
  - On the rising edge, zero_flag <= alu_zero, unless sync_reset.
  - zero_flag holds its value for every non-ALU instruction.
- Jump (ir[7:5] = 3'b111):
  - ir[4] = 0: jmp = 1.
  - ir[4] = 1: jmp_nz = 1.
  - jmp and jmp_nz are mutually exclusive.
  - The jmp_nz && !dont_jmp qualification is done in program_sequencer, not here.
- i post-increment:
  - i_incr = 1 when dm is a source (Move src = 7, dst != 7) or a destination (Load or Move dst = 7), and the instruction is not a no-op.
  - Explicit load of i wins: if reg_en[6] = 1 in the same instruction, i_incr = 0.
- The 8'hd8 instruction decodes as a normal ALU instruction: r_en = 1, x_sel = 1, y_sel = 1, alu_func = 0.
- Back-to-back instructions:
  - dont_jmp seen by a jmp_nz reflects the most recent ALU instruction.
  - An ALU instruction immediately followed by jmp_nz uses the zero flag updated at the edge between them.

Test Plan:
- Reset: hold sync_reset with pm_data = 8'hFF (would decode as jmp_nz) -> ir = 8'h80, jmp_nz = 0, all enables 0, dont_jmp = 0. Release -> next edge ir = 8'hFF, jmp_nz = 1, jmp_addr = 4'hF.
- Load: pm_data = 8'h35 -> next cycle reg_en = 8'b0000_1000 (y1), source_sel = 8, imm = 5, i_incr = 0.
- Move with dm and i edge cases:
  - 8'h8F (x1 <- dm) -> reg_en[1] = 1, source_sel = 7, i_incr = 1.
  - 8'hB7 (i <- dm) -> reg_en[6] = 1, source_sel = 7, i_incr = 0.
  - 8'h92 (y0 <- y0) -> all enables 0.
- i_pins path: 8'hA4 -> reg_en[4] = 1, source_sel = 9.
- Zero flag and jumps:
  - 8'hD8 with alu_zero = 1 -> r_en = 1, alu_func = 0; next cycle dont_jmp = 1.
  - Following 8'hF3 -> jmp_nz = 1, jmp_addr = 3, dont_jmp still 1.
  - Then 8'hE7 -> jmp = 1, jmp_addr = 7, dont_jmp unchanged.
  - 8'hD8 with alu_zero = 0 -> dont_jmp = 0.
- Reset mid-stream: assert sync_reset in the same cycle ir = 8'h8F -> reg_en = 0, i_incr = 0 that cycle; next ir = 8'h80; dont_jmp cleared to 0.
